// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller
// and anything else that talks to the 4-bit magnitude comparator.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } sar_state_e;

  // Bit positions of the comparator relation bus: target vs. trial
  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  // Settle timer width; SETTLE must stay within 1..15
  localparam int TIMER_W = 4;

  // A valid comparator answer has exactly one relation bit set
  function automatic logic cmp_onehot(input logic [2:0] i_cmp);
    return (i_cmp == 3'b001) || (i_cmp == 3'b010) || (i_cmp == 3'b100);
  endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Loadable up-counter that flags when it has reached SETTLE.
// Loading sets the count to 1 so a fresh load reaches SETTLE after
// SETTLE-1 further enabled cycles; the count parks at all-ones.
module sar_settle_timer
  import sar_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [TIMER_W-1:0] r_count;

  // Count settle cycles; a load restarts the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= TIMER_W'(1);
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_tc = (r_count == TIMER_W'(SETTLE));

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller. Drives trial values onto the
// comparator B input, samples the relation after SETTLE cycles and
// binary-searches the value on the comparator A input, MSB first.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       cmp_i,
  output logic [WIDTH-1:0] trial_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             exact_o,
  output logic             err_o,
  output logic [2:0]       steps_o
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_e         r_state;
  logic [BIT_W-1:0]   r_bit;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_trial;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;
  logic               r_exact;
  logic               r_err;
  logic [2:0]         r_steps;

  logic               w_tc;
  logic               w_onehot;
  logic               w_eq;
  logic               w_gt;
  logic [WIDTH-1:0]   w_acc_next;
  logic [BIT_W-1:0]   w_bit_dec;
  logic [WIDTH-1:0]   w_next_mask;
  logic [WIDTH-1:0]   w_msb;
  logic               w_sample;
  logic               w_continue;
  logic               w_load;

  assign w_onehot    = cmp_onehot(cmp_i);
  assign w_eq        = cmp_i[CMP_EQ];
  assign w_gt        = cmp_i[CMP_GT];
  // On "target above trial" the trial bit is kept, otherwise dropped
  assign w_acc_next  = w_gt ? r_trial : r_acc;
  assign w_bit_dec   = r_bit - BIT_W'(1);
  assign w_next_mask = {{(WIDTH-1){1'b0}}, 1'b1} << w_bit_dec;
  assign w_msb       = {1'b1, {(WIDTH-1){1'b0}}};

  assign w_sample    = (r_state == S_WAIT) && w_tc;
  assign w_continue  = w_sample && w_onehot && !w_eq && (r_bit != '0);
  assign w_load      = ((r_state == S_IDLE) && start_i) || w_continue;

  sar_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_en   (r_busy),
    .o_tc   (w_tc)
  );

  // Search FSM: issues trials, consumes comparator answers, registers outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_bit    <= '0;
      r_acc    <= '0;
      r_trial  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_exact  <= 1'b0;
      r_err    <= 1'b0;
      r_steps  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state  <= S_WAIT;
            r_busy   <= 1'b1;
            r_bit    <= BIT_W'(WIDTH - 1);
            r_acc    <= '0;
            r_trial  <= w_msb;
            r_result <= '0;
            r_exact  <= 1'b0;
            r_err    <= 1'b0;
            r_steps  <= '0;
          end
        end
        S_WAIT: begin
          if (w_tc) begin
            if (r_steps != 3'(WIDTH)) begin
              r_steps <= r_steps + 3'd1;
            end
            if (!w_onehot) begin
              // Malformed comparator answer: abort with no result
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_result <= '0;
            end else if (w_eq) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_acc    <= r_trial;
              r_result <= r_trial;
              r_exact  <= 1'b1;
            end else begin
              r_acc <= w_acc_next;
              if (r_bit != '0) begin
                r_bit   <= w_bit_dec;
                r_trial <= w_acc_next | w_next_mask;
              end else begin
                r_state  <= S_DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_result <= w_acc_next;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign trial_o  = r_trial;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;
  assign exact_o  = r_exact;
  assign err_o    = r_err;
  assign steps_o  = r_steps;

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller. It drives the B side of the team's 4-bit magnitude comparator and reads back its 3-bit relation output.
- Binary search recovers an unknown value presented on the comparator's A side.
- It is the initiator/consumer end of the comparator interface: the comparator answers "how does A relate to B", and this block issues the questions and assembles the answer.
- Sits between a start/done handshake on the control side and an external combinational comparator.

Parameters:
- WIDTH, 4: bit width of the trial value and the result.
- SETTLE, 2: clock cycles from a trial_o change to the cmp_i sample. Legal range is 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request a new search. Sampled only in IDLE.
- cmp_i  input  3  comparator relation: [2]=target>trial, [1]=target==trial, [0]=target<trial.
- trial_o  output  WIDTH  value driven to the comparator B input.
- busy_o  output  1  high while a search is in progress (state WAIT).
- done_o  output  1  one-cycle pulse when a search ends.
- result_o  output  WIDTH  recovered value. Held until the next accepted start.
- exact_o  output  1  an equality was observed during the search.
- err_o  output  1  the search aborted on a non-one-hot cmp_i.
- steps_o  output  3  number of trials issued in the last search (1..WIDTH).

Behaviour:
- Reset: rst_n low forces IDLE immediately, regardless of clk. All outputs and internal registers go to 0. This applies mid-search too; no partial result survives.
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - On start_i=1 at edge n: go to WAIT; bit = WIDTH-1; r = 0; trial_o = 1<<(WIDTH-1).
  - At the same edge, clear result_o, exact_o, err_o and steps_o to 0; set timer = 1.
- WAIT:
  - Timer increments each cycle. At the edge where timer==SETTLE, cmp_i is sampled and steps_o increments.
  - Sample one-hot and eq: r = trial_o. Go to DONE with result_o = trial_o, exact_o = 1.
  - Sample one-hot and gt: r = trial_o.
  - Sample one-hot and lt: r unchanged.
  - After gt or lt with bit > 0: bit decrements, trial_o = r | (1<<bit), timer = 1, stay in WAIT.
  - After gt or lt with bit == 0: go to DONE with result_o = r, exact_o = 0.
  - Sample not one-hot (000, or more than one bit set): go to DONE with err_o = 1, result_o = 0.
- DONE: done_o = 1 for exactly this cycle; next edge returns to IDLE. start_i is ignored in DONE.
- trial_o holds its last value in DONE and IDLE until the next start.
- busy_o = (state == WAIT).
- start_i is ignored while busy; it is not queued.
- Latency for a search of k trials: done_o is high in the cycle after edge n + k*SETTLE, with k ≤ WIDTH.
- Boundary cases:
  - Target 0 gives all-lt: result 0, exact 0, steps WIDTH.
  - Target 2^(WIDTH-1) ends after the first trial.
  - A target of all ones finishes exact on the final trial.
- Width rules: steps_o saturates at WIDTH, which fits 3 bits for WIDTH ≤ 7. The timer width is 4 bits.

Decomposition:
- Shared package sar_pkg:
  - State enum (IDLE, WAIT, DONE).
  - Comparator index constants CMP_GT=2, CMP_EQ=1, CMP_LT=0, reused by the comparator wrappers and benches.
- One sub-module, sar_settle_timer: loadable up-counter with a terminal flag at SETTLE. It is shared with future polling blocks.
- The bench instantiates the existing 4-bit comparator as the target model, with A tied to the target value.

Test Plan:
- Target 11, SETTLE=2, start pulse at edge n -> trial_o sequence 8, 12, 10, 11. done_o high in the cycle after edge n+8. result_o=11, exact_o=1, steps_o=4, err_o=0.
- Target 8 -> single trial 8 with eq. done_o high after edge n+2. result_o=8, steps_o=1, exact_o=1.
- Target 0 -> trials 8, 4, 2, 1, all lt. result_o=0, exact_o=0, steps_o=4. Target 15 -> trials 8, 12, 14, 15. result_o=15, exact_o=1.
- Force cmp_i=3'b000 (then separately 3'b101) at the first sample -> done_o pulse after edge n+2, err_o=1, result_o=0, steps_o=1.
- Pulse start_i while busy_o=1 and during the DONE cycle -> ignored; trial sequence unchanged; exactly one done_o pulse per accepted start.
- Drop rst_n mid-search (second trial) between clock edges -> all outputs 0 immediately. After release, start with target 5 -> trials 8, 4, 6, 5 and result_o=5.
